mac_acc_array: RTL and testbench
================================

# mac_acc_array

Parametrised, pipelined dot-product accumulator; successor to the 4-input chained MAC wrapper. Each valid beat multiplies `lanes` unsigned activations by `lanes` signed weights, reduces them in an adder tree, and accumulates across multiple beats, seeded by `psum_in` on the first beat. A result is emitted on the last beat. It sits between the activation/weight feeders and the psum writeback path of the PE array.

## Interface
- `bw`, 4, activation/weight width.
- `lanes`, 4, products per beat.
- `psum_bw`, 16, accumulator/output width; must be ≥ 2·bw+1+clog2(lanes).
- `cnt_bw`, 8, beat-counter width.

- `clk` in 1: clock.
- `reset` in 1: active-high, synchronous.
- `in_valid` in 1: beat valid.
- `first` in 1: beat opens an accumulation (qualified by `in_valid`).
- `last` in 1: beat closes an accumulation (qualified by `in_valid`).
- `sat_en` in 1: per-beat; 1 = saturate, 0 = wrap.
- `x` in lanes·bw: activations, unsigned; lane i at [i·bw +: bw].
- `w` in lanes·bw: weights, two's complement; same packing.
- `psum_in` in psum_bw: signed seed, used only on `first` beats.
- `out` out psum_bw: signed accumulated result.
- `out_valid` out 1: single-cycle pulse when `out` is updated.
- `busy` out 1: an accumulation is open.
- `beat_cnt` out cnt_bw: beats in the current or last accumulation.
- `ovf` out 1: sticky signed overflow in the current accumulation.

## Operation
- S1: when `in_valid`, register `x`, `w`, `psum_in`, `first`, `last`, `sat_en`. The valid bit is carried through every stage.
- S2: per lane, compute the product {1'b0,x_i}·w_i, a signed 2·bw+1-bit value. Sum all lanes, sign-extend to psum_bw, and register with the control bits.
- S3: base = `psum_in` if `first`, else `acc`. Form sum = base + dot at psum_bw+1 bits.
  - Overflow = sum is outside the signed psum_bw range.
  - `sat_en`=1 and overflow: clamp to 2^(psum_bw-1)-1 or -2^(psum_bw-1).
  - `sat_en`=0: keep the low psum_bw bits (wrap).
- `ovf`: set on any overflow. A `first` beat loads `ovf` with that beat's overflow, which clears any prior value.
- `beat_cnt`: a `first` beat loads 1; each other valid beat increments it, saturating at all-ones.
- `busy`: set by a `first` beat without `last`; cleared by a `last` beat.
- `last` beat: `out` ← new acc and `out_valid`=1 for one cycle. Otherwise `out` holds its value.
- Beat with `first`=`last`=1: single-beat result, psum_in + dot.
- Non-`first` beat with no open accumulation: continues from the retained `acc`; `busy` stays 0 unless it is without `last`, in which case `busy`=1.
- `in_valid`=0: bubble; no state change in S3.
- No backpressure: every valid beat is accepted.

## Timing
- Beat sampled at the edge ending cycle n → S1 in cycle n+1 → S2 in n+2 → `out`/`out_valid`/`acc`/`busy`/`beat_cnt`/`ovf` visible in cycle n+3. Latency is 3, throughput is 1 beat/cycle.
- `busy`, `beat_cnt` and `ovf` reflect S3 state, so they also lag the input by 3 cycles.
- Back-to-back: a `last` beat in cycle n followed by a `first` beat in cycle n+1 gives `out_valid` in n+3. The following accumulation is unaffected.
- Reset: on the edge with `reset`=1, all stage valids, `acc`, `out`, `out_valid`, `busy`, `beat_cnt` and `ovf` become 0. In-flight beats are discarded and no `out_valid` is produced for them. Beats presented while `reset`=1 are ignored.

## Structure
- Shared package `mac_pkg`:
  - default widths;
  - the product width function (2·bw+1);
  - the tree width function (+clog2(lanes));
  - saturation limit constants derived from psum_bw.
- Sub-module `mac_dot_tree`: lanes products plus a balanced adder tree. It is combinational and sits inside S2. The top level holds the S1/S2/S3 pipeline registers and the accumulator control.

## Test plan
- Single beat, first=last=1, x={1,2,3,4}, w={1,1,1,1}, psum_in=5 → out=15 (16'h000F) in cycle n+3; `out_valid` high for exactly 1 cycle; beat_cnt=1; ovf=0.
- Signed weights: x all 15, w all 4'h8 (−8), psum_in=0 → out=−480 (16'hFE20).
- Three beats each with dot=10 (x={10,0,0,0}, w={1,0,0,0}), psum_in=100, 1-cycle bubble before beat 3:
  - out=130; beat_cnt=3; busy high from the first beat's S3 cycle through the last beat's S3 cycle;
  - exactly one `out_valid` pulse.
- Overflow: psum_in=32700, x={15,15,0,0}, w={4,4,0,0} (dot=120), single beat:
  - sat_en=1 → out=32767, ovf=1;
  - sat_en=0 → out=−32716 (16'h8034), ovf=1;
  - a subsequent clean single beat → ovf=0.
- Reset mid-accumulation: first beat, then a second beat, then reset for 1 cycle, then last beat → no `out_valid` and all outputs 0 after reset. A fresh first=last beat then gives the correct result with beat_cnt=1.
- Back-to-back: A = 2 beats (dot 5, 7, psum_in=0), then B = 1 beat (dot 3, psum_in=1) in the next cycle → out=12, then out=4 in consecutive cycles.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and helpers for the dot-product accumulator slice.
package mac_pkg;

  localparam int unsigned default_bw      = 4;
  localparam int unsigned default_lanes   = 4;
  localparam int unsigned default_psum_bw = 16;
  localparam int unsigned default_cnt_bw  = 8;

  // {1'b0,x} * w: (bw+1)-bit signed times bw-bit signed.
  function automatic int unsigned prod_width(int unsigned bw);
    return 2 * bw + 1;
  endfunction

  function automatic int unsigned tree_width(int unsigned bw, int unsigned lanes);
    return prod_width(bw) + $clog2(lanes);
  endfunction

  function automatic longint sat_max_of(int unsigned psum_bw);
    return (64'sd1 <<< (psum_bw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min_of(int unsigned psum_bw);
    return -(64'sd1 <<< (psum_bw - 1));
  endfunction

  localparam longint default_sat_max = sat_max_of(default_psum_bw);
  localparam longint default_sat_min = sat_min_of(default_psum_bw);

endpackage

// File: rtl/mac_acc_array_if.sv
// Beat/result bundle between the feeders, the accumulator and psum writeback.
interface mac_acc_array_if
  import mac_pkg::*;
#(
  parameter int unsigned bw      = default_bw,
  parameter int unsigned lanes   = default_lanes,
  parameter int unsigned psum_bw = default_psum_bw,
  parameter int unsigned cnt_bw  = default_cnt_bw
);

  logic                    in_valid;
  logic                    first;
  logic                    last;
  logic                    sat_en;
  logic [lanes*bw-1:0]     x;
  logic [lanes*bw-1:0]     w;
  logic [psum_bw-1:0]      psum_in;
  logic [psum_bw-1:0]      out;
  logic                    out_valid;
  logic                    busy;
  logic [cnt_bw-1:0]       beat_cnt;
  logic                    ovf;

  modport master (
    output in_valid, first, last, sat_en, x, w, psum_in,
    input  out, out_valid, busy, beat_cnt, ovf
  );

  modport slave (
    input  in_valid, first, last, sat_en, x, w, psum_in,
    output out, out_valid, busy, beat_cnt, ovf
  );

endinterface

// File: rtl/mac_dot_tree.sv
// Combinational lane products (unsigned x times signed w) and a balanced adder tree.
module mac_dot_tree
  import mac_pkg::*;
#(
  parameter int unsigned bw    = default_bw,
  parameter int unsigned lanes = default_lanes
) (
  input  logic [lanes*bw-1:0]                     x,
  input  logic [lanes*bw-1:0]                     w,
  output logic signed [tree_width(bw, lanes)-1:0] dot
);

  localparam int unsigned pw     = prod_width(bw);
  localparam int unsigned tw     = tree_width(bw, lanes);
  localparam int unsigned levels = $clog2(lanes);
  localparam int unsigned n_pad  = 1 << levels;

  // Level 0 holds the products, padded with zeros up to a power of two.
  for (genvar l = 0; l <= levels; l++) begin : g_lvl
    logic signed [tw-1:0] node [n_pad >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < n_pad; i++) begin : g_lane
        if (i < lanes) begin : g_prod
          logic signed [pw-1:0] xa, wa, prod;
          assign xa      = pw'($signed({1'b0, x[i*bw +: bw]}));
          assign wa      = pw'($signed(w[i*bw +: bw]));
          assign prod    = xa * wa;
          assign node[i] = tw'(prod);
        end else begin : g_zero
          assign node[i] = '0;
        end
      end
    end else begin : g_sum
      for (genvar i = 0; i < (n_pad >> l); i++) begin : g_add
        assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end
    end
  end

  assign dot = g_lvl[levels].node[0];

endmodule

// File: rtl/mac_acc_array.sv
// Three-stage dot-product accumulator: S1 input regs, S2 products/tree, S3 accumulate.
module mac_acc_array
  import mac_pkg::*;
#(
  parameter int unsigned bw      = default_bw,
  parameter int unsigned lanes   = default_lanes,
  parameter int unsigned psum_bw = default_psum_bw,
  parameter int unsigned cnt_bw  = default_cnt_bw
) (
  input logic           clk,
  input logic           reset,
  mac_acc_array_if.slave bus
);

  localparam int unsigned tw = tree_width(bw, lanes);
  localparam int unsigned sw = psum_bw + 1;
  localparam logic [psum_bw-1:0] sat_max = psum_bw'(sat_max_of(psum_bw));
  localparam logic [psum_bw-1:0] sat_min = psum_bw'(sat_min_of(psum_bw));

  logic                s1_valid_q, s1_first_q, s1_last_q, s1_sat_q;
  logic [lanes*bw-1:0] s1_x_q, s1_w_q;
  logic [psum_bw-1:0]  s1_psum_q;

  logic                s2_valid_q, s2_first_q, s2_last_q, s2_sat_q;
  logic signed [psum_bw-1:0] s2_dot_q, s2_psum_q;

  logic signed [tw-1:0] dot;

  logic signed [psum_bw-1:0] acc_q, acc_d, out_q, out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic [cnt_bw-1:0]         beat_cnt_q, beat_cnt_d;
  logic                      ovf_q, ovf_d;

  logic signed [psum_bw-1:0] base;
  logic signed [sw-1:0]      sum;
  logic                      of;
  logic signed [psum_bw-1:0] res;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.in_valid;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Payload registers only follow their stage valid; they need no reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      s1_first_q <= bus.first;
      s1_last_q  <= bus.last;
      s1_sat_q   <= bus.sat_en;
      s1_x_q     <= bus.x;
      s1_w_q     <= bus.w;
      s1_psum_q  <= bus.psum_in;
    end
    if (s1_valid_q) begin
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_sat_q   <= s1_sat_q;
      s2_dot_q   <= psum_bw'(dot);
      s2_psum_q  <= s1_psum_q;
    end
  end

  mac_dot_tree #(
    .bw    (bw),
    .lanes (lanes)
  ) u_dot_tree (
    .x   (s1_x_q),
    .w   (s1_w_q),
    .dot (dot)
  );

  always_comb begin
    base = s2_first_q ? s2_psum_q : acc_q;
    sum  = sw'(base) + sw'(s2_dot_q);
    of   = sum[psum_bw] ^ sum[psum_bw-1];
    res  = sum[psum_bw-1:0];
    if (of && s2_sat_q) begin
      res = sum[psum_bw] ? sat_min : sat_max;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    beat_cnt_d  = beat_cnt_q;
    ovf_d       = ovf_q;
    if (s2_valid_q) begin
      acc_d  = res;
      busy_d = ~s2_last_q;
      ovf_d  = s2_first_q ? of : (ovf_q | of);
      if (s2_first_q) begin
        beat_cnt_d = cnt_bw'(1);
      end else if (!(&beat_cnt_q)) begin
        beat_cnt_d = beat_cnt_q + cnt_bw'(1);
      end
      if (s2_last_q) begin
        out_d       = res;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      beat_cnt_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      beat_cnt_q  <= beat_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.beat_cnt  = beat_cnt_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_acc_array.sv
// Scoreboarded bench for mac_acc_array: an integer reference model predicts results at drive time.
module tb_mac_acc_array;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_acc_array_if bus ();

  mac_acc_array dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [15:0] exp_q[$];
  int pulse_cyc[$];
  int pulses = 0;

  // Reference state after the most recently presented beat.
  int m_acc = 0, m_cnt = 0;
  bit m_busy = 1'b0, m_ovf = 1'b0;
  // Model state delayed to line up with the DUT's 3-cycle latency.
  int hb[3], hc[3], ho[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model(input bit f, input bit l, input bit s,
                       input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] ps);
    int dot, base, sum;
    bit of;
    logic [3:0] xs;
    logic signed [3:0] ws;
    logic [15:0] t;
    dot = 0;
    for (int i = 0; i < 4; i++) begin
      xs = xv[i*4 +: 4];
      ws = wv[i*4 +: 4];
      dot += int'(xs) * int'(ws);
    end
    base = f ? int'($signed(ps)) : m_acc;
    sum  = base + dot;
    of   = (sum > 32767) || (sum < -32768);
    if (of && s) begin
      sum = (sum > 0) ? 32767 : -32768;
    end else begin
      t   = sum[15:0];
      sum = int'($signed(t));
    end
    m_acc  = sum;
    m_ovf  = f ? of : (m_ovf | of);
    m_cnt  = f ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
    m_busy = !l;
    if (l) begin
      t = sum[15:0];
      exp_q.push_back(t);
    end
  endtask

  task automatic beat(input bit f, input bit l, input bit s,
                      input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] ps);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.first    = f;
    bus.last     = l;
    bus.sat_en   = s;
    bus.x        = xv;
    bus.w        = wv;
    bus.psum_in  = ps;
    model(f, l, s, xv, wv, ps);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Reset for one cycle while a last beat is presented; that beat must be ignored.
  task automatic reset_with_beat();
    @(posedge clk);
    #1;
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.first    = 1'b0;
    bus.last     = 1'b1;
    bus.sat_en   = 1'b0;
    bus.x        = 16'hA000;
    bus.w        = 16'h1000;
    m_acc = 0; m_cnt = 0; m_busy = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    idle(1);
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    idle(4);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        hb = '{0, 0, 0}; hc = '{0, 0, 0}; ho = '{0, 0, 0};
      end else begin
        hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = int'(m_busy);
        hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = m_cnt;
        ho[2] = ho[1]; ho[1] = ho[0]; ho[0] = int'(m_ovf);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        check("busy", 32'(bus.busy), 32'(hb[2]));
        check("beat_cnt", 32'(bus.beat_cnt), 32'(hc[2]));
        check("ovf", 32'(bus.ovf), 32'(ho[2]));
        if (bus.out_valid !== 1'b0) begin
          if (exp_q.size() == 0) check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
          else check("out", 32'(bus.out), 32'(exp_q.pop_front()));
          pulses++;
          pulse_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int p0, ca, cb;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.first = 1'b0; bus.last = 1'b0; bus.sat_en = 1'b0;
    bus.x = '0; bus.w = '0; bus.psum_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cnt", 32'(bus.beat_cnt), 32'd0);

    // Single beat, then out_valid lands exactly 3 cycles later.
    p0 = pulses;
    beat(1, 1, 0, 16'h1234, 16'h1111, 16'd5);
    ca = cyc;
    drain();
    check("t1_out", 32'(bus.out), 32'h000F);
    check("t1_cnt", 32'(bus.beat_cnt), 32'd1);
    check("t1_ovf", 32'(bus.ovf), 32'd0);
    check("t1_pulses", 32'(pulses - p0), 32'd1);
    check("t1_latency", 32'(pulse_cyc[$] - ca), 32'd3);

    beat(1, 1, 0, 16'hFFFF, 16'h8888, 16'd0);
    drain();
    check("t2_out", 32'(bus.out), 32'hFE20);

    // Three beats of dot 10 with a bubble before the last.
    p0 = pulses;
    beat(1, 0, 0, 16'hA000, 16'h1000, 16'd100);
    beat(0, 0, 0, 16'hA000, 16'h1000, 16'd0);
    idle(1);
    beat(0, 1, 0, 16'hA000, 16'h1000, 16'd0);
    drain();
    check("t3_out", 32'(bus.out), 32'd130);
    check("t3_cnt", 32'(bus.beat_cnt), 32'd3);
    check("t3_pulses", 32'(pulses - p0), 32'd1);

    beat(1, 1, 1, 16'h00FF, 16'h0044, 16'd32700);
    drain();
    check("sat_out", 32'(bus.out), 32'h7FFF);
    check("sat_ovf", 32'(bus.ovf), 32'd1);
    beat(1, 1, 0, 16'h00FF, 16'h0044, 16'd32700);
    drain();
    check("wrap_out", 32'(bus.out), 32'h8034);
    check("wrap_ovf", 32'(bus.ovf), 32'd1);
    beat(1, 1, 0, 16'h1234, 16'h1111, 16'd5);
    drain();
    check("clean_ovf", 32'(bus.ovf), 32'd0);

    // Reset mid-accumulation discards in-flight beats.
    p0 = pulses;
    beat(1, 0, 0, 16'hA000, 16'h1000, 16'd0);
    beat(0, 0, 0, 16'hA000, 16'h1000, 16'd0);
    reset_with_beat();
    idle(6);
    @(negedge clk);
    check("rst2_pulses", 32'(pulses - p0), 32'd0);
    check("rst2_out", 32'(bus.out), 32'd0);
    check("rst2_busy", 32'(bus.busy), 32'd0);
    check("rst2_cnt", 32'(bus.beat_cnt), 32'd0);
    check("rst2_ovf", 32'(bus.ovf), 32'd0);
    beat(1, 1, 0, 16'h1234, 16'h1111, 16'd5);
    drain();
    check("fresh_out", 32'(bus.out), 32'h000F);
    check("fresh_cnt", 32'(bus.beat_cnt), 32'd1);

    // Back-to-back accumulations: results in consecutive cycles.
    beat(1, 0, 0, 16'h5000, 16'h1000, 16'd0);
    beat(0, 1, 0, 16'h7000, 16'h1000, 16'd0);
    beat(1, 1, 0, 16'h3000, 16'h1000, 16'd1);
    drain();
    check("b2b_out", 32'(bus.out), 32'd4);
    cb = pulse_cyc[$];
    ca = pulse_cyc[$-1];
    check("b2b_gap", 32'(cb - ca), 32'd1);

    for (int i = 0; i < 40; i++) begin
      beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom), 16'($urandom), 16'($urandom));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
